// File: rtl/fp_mul_lane_pkg.sv
// Shared types and helpers for the multi-lane FP32 multiply engine.
//   lane_state_t : per-lane handshake state (IDLE, SEND_A, SEND_B, WAIT_Z, HOLD)
//   lane_idx_w() : pointer width for a given lane count, never below 1 bit
package fp_mul_lane_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        HOLD   = 3'd4
    } lane_state_t;

    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_mul_lane_ctrl.sv
// One lane of the multiply engine: operand/tag/result registers, the lane
// FSM that feeds one multiplier over its stb/ack handshakes, and the
// multiplier instance itself.
// Ports:
//   clk, rst        clock, sync active-high reset (also resets the multiplier)
//   start           dispatch this request into the lane (only honoured in IDLE)
//   drain           result taken by the consumer (only honoured in HOLD)
//   a, b, tag       request operands and tag
//   state           current lane state
//   z, tag_out      held result and its tag
module fp_mul_lane_ctrl
    import fp_mul_lane_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              drain,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [TAG_W-1:0]  tag,
    output lane_state_t       state,
    output logic [DATA_W-1:0] z,
    output logic [TAG_W-1:0]  tag_out
);

    lane_state_t       state_r, state_nxt_s;
    logic [DATA_W-1:0] a_r, b_r, z_r, mul_z_s;
    logic [TAG_W-1:0]  tag_r;
    logic              a_stb_s, a_ack_s, b_stb_s, b_ack_s, z_stb_s, z_ack_s;

    // Strobes are pure state decodes, so operands held in a_r/b_r stay stable under them
    assign a_stb_s = (state_r == SEND_A);
    assign b_stb_s = (state_r == SEND_B);
    assign z_ack_s = (state_r == WAIT_Z);

    assign state   = state_r;
    assign z       = z_r;
    assign tag_out = tag_r;

    // Lane next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (start)   state_nxt_s = SEND_A; else state_nxt_s = IDLE;
            SEND_A:  if (a_ack_s) state_nxt_s = SEND_B; else state_nxt_s = SEND_A;
            SEND_B:  if (b_ack_s) state_nxt_s = WAIT_Z; else state_nxt_s = SEND_B;
            WAIT_Z:  if (z_stb_s) state_nxt_s = HOLD;   else state_nxt_s = WAIT_Z;
            HOLD:    if (drain)   state_nxt_s = IDLE;   else state_nxt_s = HOLD;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Lane state, request capture on dispatch, result capture on multiplier strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            z_r     <= {DATA_W{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE && start) begin
                a_r   <= a;
                b_r   <= b;
                tag_r <= tag;
            end
            if (state_r == WAIT_Z && z_stb_s) z_r <= mul_z_s;
        end
    end

    fp_multiplier_booth_csa u_mul (
        .clk          (clk),
        .rst          (rst),
        .input_a      (a_r),
        .input_a_stb  (a_stb_s),
        .input_a_ack  (a_ack_s),
        .input_b      (b_r),
        .input_b_stb  (b_stb_s),
        .input_b_ack  (b_ack_s),
        .output_z     (mul_z_s),
        .output_z_stb (z_stb_s),
        .output_z_ack (z_ack_s)
    );

endmodule

// File: rtl/fp_multiplier_booth_csa.sv
// FP32 multiplier with stb/ack handshakes on each operand and on the result.
// Denormal inputs are treated as zero and underflowing results flush to
// signed zero; rounding is round-to-nearest-even; every NaN result is the
// canonical quiet NaN 0x7FC00000.
// Ports:
//   clk, rst                          clock, sync active-high reset
//   input_a/_stb/_ack                 operand A handshake (ack high while waiting for A)
//   input_b/_stb/_ack                 operand B handshake (ack high while waiting for B)
//   output_z/_stb/_ack                result handshake (stb high while result offered)
module fp_multiplier_booth_csa (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        M_GET_A = 3'd0,
        M_GET_B = 3'd1,
        M_MUL   = 3'd2,
        M_PACK  = 3'd3,
        M_PUT_Z = 3'd4
    } mul_state_t;

    mul_state_t        state_r, state_nxt_s;
    logic [31:0]       a_r, b_r, z_r, spec_z_r, spec_z_s, pack_z_s;
    logic [47:0]       prod_r;
    logic signed [9:0] exp_r, exp_n_s, exp_f_s;
    logic              sign_r, spec_r, spec_hit_s, sign_s;
    logic [23:0]       mant_s;
    logic [24:0]       mant_rnd_s;
    logic [22:0]       frac_s;
    logic              guard_s, sticky_s, round_up_s;
    logic              zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;

    assign input_a_ack  = (state_r == M_GET_A);
    assign input_b_ack  = (state_r == M_GET_B);
    assign output_z_stb = (state_r == M_PUT_Z);
    assign output_z     = z_r;

    assign sign_s   = a_r[31] ^ b_r[31];
    assign zero_a_s = (a_r[30:23] == 8'h00);
    assign zero_b_s = (b_r[30:23] == 8'h00);
    assign inf_a_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
    assign inf_b_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
    assign nan_a_s  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
    assign nan_b_s  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);

    // Next-state logic of the handshake/compute sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            M_GET_A: if (input_a_stb)  state_nxt_s = M_GET_B; else state_nxt_s = M_GET_A;
            M_GET_B: if (input_b_stb)  state_nxt_s = M_MUL;   else state_nxt_s = M_GET_B;
            M_MUL:   state_nxt_s = M_PACK;
            M_PACK:  state_nxt_s = M_PUT_Z;
            M_PUT_Z: if (output_z_ack) state_nxt_s = M_GET_A; else state_nxt_s = M_PUT_Z;
            default: state_nxt_s = M_GET_A;
        endcase
    end

    // Special-operand results (NaN, infinity, zero) bypass the mantissa path
    always_comb begin
        spec_hit_s = 1'b1;
        spec_z_s   = 32'h7FC0_0000;
        if (nan_a_s || nan_b_s) begin
            spec_z_s = 32'h7FC0_0000;
        end else if (inf_a_s || inf_b_s) begin
            if (zero_a_s || zero_b_s) spec_z_s = 32'h7FC0_0000;
            else                      spec_z_s = {sign_s, 8'hFF, 23'd0};
        end else if (zero_a_s || zero_b_s) begin
            spec_z_s = {sign_s, 31'd0};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // Normalise the 48-bit product, round to nearest even, clamp exponent
    always_comb begin
        if (prod_r[47]) begin
            mant_s   = prod_r[47:24];
            guard_s  = prod_r[23];
            sticky_s = |prod_r[22:0];
            exp_n_s  = exp_r + 10'sd1;
        end else begin
            mant_s   = prod_r[46:23];
            guard_s  = prod_r[22];
            sticky_s = |prod_r[21:0];
            exp_n_s  = exp_r;
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {24'd0, round_up_s};
        if (mant_rnd_s[24]) begin
            frac_s  = mant_rnd_s[23:1];
            exp_f_s = exp_n_s + 10'sd1;
        end else begin
            frac_s  = mant_rnd_s[22:0];
            exp_f_s = exp_n_s;
        end
        if (exp_f_s >= 10'sd255)    pack_z_s = {sign_r, 8'hFF, 23'd0};
        else if (exp_f_s <= 10'sd0) pack_z_s = {sign_r, 31'd0};
        else                        pack_z_s = {sign_r, exp_f_s[7:0], frac_s};
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= M_GET_A;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            z_r      <= 32'd0;
            prod_r   <= 48'd0;
            exp_r    <= 10'sd0;
            sign_r   <= 1'b0;
            spec_r   <= 1'b0;
            spec_z_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == M_GET_A && input_a_stb) a_r <= input_a;
            if (state_r == M_GET_B && input_b_stb) b_r <= input_b;
            if (state_r == M_MUL) begin
                prod_r   <= {24'd0, 1'b1, a_r[22:0]} * {24'd0, 1'b1, b_r[22:0]};
                exp_r    <= $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127;
                sign_r   <= sign_s;
                spec_r   <= spec_hit_s;
                spec_z_r <= spec_z_s;
            end
            if (state_r == M_PACK) z_r <= spec_r ? spec_z_r : pack_z_s;
        end
    end

endmodule

// File: rtl/fp_mul_lane_array.sv
// Multi-lane FP32 multiply engine. Requests are dispatched round-robin to
// NUM_LANES lanes; results are collected round-robin in the same order, so
// responses always leave in request-accept order.
// Optional feature macro: FP_MUL_LANE_PERF_EN adds perf_ops / perf_stall.
// Ports:
//   clk, rst                        clock, sync active-high reset
//   req_valid/req_ready             request handshake; req_a, req_b, req_tag payload
//   rsp_valid/rsp_ready             response handshake; rsp_z, rsp_tag payload
//   busy                            any lane not IDLE
//   perf_ops, perf_stall            accepted requests / stalled request cycles (macro only)
module fp_mul_lane_array
    import fp_mul_lane_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_z,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
`ifdef FP_MUL_LANE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    localparam int LANE_IDX_W = lane_idx_w(NUM_LANES);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("fp_mul_lane_array: DATA_W must be 32");
    end
    if (NUM_LANES < 1 || NUM_LANES > 16 || (NUM_LANES & (NUM_LANES - 1)) != 0) begin : g_bad_lanes
        $error("fp_mul_lane_array: NUM_LANES must be a power of 2 in 1..16");
    end

    lane_state_t           lane_state_s [NUM_LANES];
    logic [DATA_W-1:0]     lane_z_s     [NUM_LANES];
    logic [TAG_W-1:0]      lane_tag_s   [NUM_LANES];
    logic [NUM_LANES-1:0]  lane_idle_s;
    logic [LANE_IDX_W-1:0] disp_ptr_r, coll_ptr_r;
    logic                  accept_s, rsp_fire_s;

    function automatic logic [LANE_IDX_W-1:0] ptr_next(input logic [LANE_IDX_W-1:0] p);
        if (p == LANE_IDX_W'(NUM_LANES - 1)) return {LANE_IDX_W{1'b0}};
        else                                 return p + LANE_IDX_W'(1);
    endfunction

    // Readiness depends only on lane state, never on req_valid; a lane drained
    // this cycle shows IDLE (and becomes dispatchable) only on the next one.
    assign req_ready  = (lane_state_s[disp_ptr_r] == IDLE);
    assign rsp_valid  = (lane_state_s[coll_ptr_r] == HOLD);
    assign rsp_z      = lane_z_s[coll_ptr_r];
    assign rsp_tag    = lane_tag_s[coll_ptr_r];
    assign busy       = ~(&lane_idle_s);
    assign accept_s   = req_valid && req_ready;
    assign rsp_fire_s = rsp_valid && rsp_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_idle_s[i] = (lane_state_s[i] == IDLE);
        fp_mul_lane_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .start   (accept_s && (disp_ptr_r == LANE_IDX_W'(i))),
            .drain   (rsp_fire_s && (coll_ptr_r == LANE_IDX_W'(i))),
            .a       (req_a),
            .b       (req_b),
            .tag     (req_tag),
            .state   (lane_state_s[i]),
            .z       (lane_z_s[i]),
            .tag_out (lane_tag_s[i])
        );
    end

    // Dispatch and collect pointers advance on their handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_ptr_r <= {LANE_IDX_W{1'b0}};
            coll_ptr_r <= {LANE_IDX_W{1'b0}};
        end else begin
            if (accept_s)   disp_ptr_r <= ptr_next(disp_ptr_r);
            if (rsp_fire_s) coll_ptr_r <= ptr_next(coll_ptr_r);
        end
    end

`ifdef FP_MUL_LANE_PERF_EN
    logic [31:0] perf_ops_r, perf_stall_r;

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (accept_s)                perf_ops_r   <= perf_ops_r + 32'd1;
            if (req_valid && !req_ready) perf_stall_r <= perf_stall_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_lane_array.sv
// Directed bench for fp_mul_lane_array with a request-order scoreboard.
module tb_fp_mul_lane_array;

    localparam int NL = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = 32'd0;
    logic [DW-1:0] req_b = 32'd0;
    logic [TW-1:0] req_tag = 4'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_z;
    logic [TW-1:0] rsp_tag;
    logic          busy;
`ifdef FP_MUL_LANE_PERF_EN
    logic [31:0]   perf_ops, perf_stall;
`endif

    fp_mul_lane_array #(.NUM_LANES(NL), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
`ifdef FP_MUL_LANE_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] z;
    } exp_t;

    exp_t          sb_q[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            acc_cyc = -1;
    int            n_acc = 0;
    int            n_stall = 0;
    logic [DW-1:0] pend_z = 32'd0;
    bit            rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Reference: normal operands whose product stays in the normal range
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [23:0] m;
        int          e;
        logic        rb, st;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) e = e + 1;
        else       p = p << 1;
        m  = p[47:24];
        rb = p[23];
        st = |p[22:0];
        if (rb && (st || m[0])) begin
            if (m == 24'hFFFFFF) begin
                m = 24'h800000;
                e = e + 1;
            end else begin
                m = m + 24'd1;
            end
        end
        return {a[31] ^ b[31], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(100, 154));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    // One clock: observe handshakes, update scoreboard, then advance
    task automatic step();
        exp_t          e;
        logic          held;
        logic [DW-1:0] hz;
        logic [TW-1:0] ht;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                chk("rsp_z", 64'(rsp_z), 64'(e.z));
            end
        end
        if (req_valid && req_ready) begin
            sb_q.push_back({req_tag, pend_z});
            acc_cyc = cyc;
            n_acc   = n_acc + 1;
        end
        if (req_valid && !req_ready) n_stall = n_stall + 1;
        held = rsp_valid && !rsp_ready && !rst;
        hz   = rsp_z;
        ht   = rsp_tag;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (held) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_z", 64'(rsp_z), 64'(hz));
            chk("stall_tag", 64'(rsp_tag), 64'(ht));
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag,
                        input logic [31:0] ez);
        bit accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        pend_z    = ez;
        for (int k = 0; k < 200 && !accepted; k++) begin
            if (req_ready) accepted = 1'b1;
            step();
        end
        req_valid = 1'b0;
        chk("send_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && (busy || sb_q.size() != 0); k++) step();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_sb_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_z", 64'(rsp_z), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
`ifdef FP_MUL_LANE_PERF_EN
        chk("rst_perf_ops", 64'(perf_ops), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        rst = 1'b0;
        step();

        // 2.0 * 3.0 = 6.0, with accept-to-valid latency
        rsp_ready = 1'b1;
        send(32'h4000_0000, 32'h4040_0000, 4'd5, 32'h40C0_0000);
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        chk("t1_latency", 64'(cyc - acc_cyc), 64'd6);
        chk("t1_tag_present", 64'(rsp_tag), 64'd5);
        step();
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_valid_after", 64'(rsp_valid), 64'd0);

        // Fill all lanes with consumer stalled, fifth waits for first drain
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 4'(i + 1), ref_mul(ra, rb));
        end
        chk("t2_full_ready", 64'(req_ready), 64'd0);
        chk("t2_full_busy", 64'(busy), 64'd1);
        ra = rnd_op();
        rb = rnd_op();
        req_valid = 1'b1;
        req_a     = ra;
        req_b     = rb;
        req_tag   = 4'd6;
        pend_z    = ref_mul(ra, rb);
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        chk("t2_first_valid", 64'(rsp_valid), 64'd1);
        chk("t2_still_full", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        step();
        chk("t2_ready_after_drain", 64'(req_ready), 64'd1);
        step();
        chk("t2_fifth_accepted", 64'(cyc - 1 - acc_cyc), 64'd0);
        req_valid = 1'b0;
        wait_idle();

        // Inf * 0 -> canonical NaN passed straight through
        send(32'h7F80_0000, 32'h0000_0000, 4'd9, 32'h7FC0_0000);
        wait_idle();

        // Tags 0..15 with random operands and random consumer back-pressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 16; t++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 4'(t), ref_mul(ra, rb));
        end
        wait_idle();
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;

        // Reset with three lanes in WAIT_Z/HOLD
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 4'(i + 10), ref_mul(ra, rb));
        end
        for (int k = 0; k < 4; k++) step();
        chk("t5_busy_before", 64'(busy), 64'd1);
        chk("t5_valid_before", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b0;
        sb_q.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t5_no_stale", 64'(rsp_valid), 64'd0);
        end
        send(32'h4000_0000, 32'h4040_0000, 4'd3, 32'h40C0_0000);
        wait_idle();

`ifdef FP_MUL_LANE_PERF_EN
        // 20 accepts and 7 stall cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        n_acc   = 0;
        n_stall = 0;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 4'(i), ref_mul(ra, rb));
        end
        req_valid = 1'b1;
        for (int k = 0; k < 7; k++) step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                ra = rnd_op();
                rb = rnd_op();
                send(ra, rb, 4'(i), ref_mul(ra, rb));
            end
            wait_idle();
        end
        chk("perf_bench_acc", 64'(n_acc), 64'd20);
        chk("perf_ops", 64'(perf_ops), 64'd20);
        chk("perf_stall", 64'(perf_stall), 64'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("perf_ops_rst", 64'(perf_ops), 64'd0);
        chk("perf_stall_rst", 64'(perf_stall), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
